// File: rtl/cpu54_pkg.sv
// rtl/cpu54_pkg.sv - shared ALU opcode and operand-select encodings
package cpu54_pkg;

  localparam logic [3:0] ALUC_ADDU = 4'd0;
  localparam logic [3:0] ALUC_SUBU = 4'd1;
  localparam logic [3:0] ALUC_ADD  = 4'd2;
  localparam logic [3:0] ALUC_SUB  = 4'd3;
  localparam logic [3:0] ALUC_AND  = 4'd4;
  localparam logic [3:0] ALUC_OR   = 4'd5;
  localparam logic [3:0] ALUC_XOR  = 4'd6;
  localparam logic [3:0] ALUC_NOR  = 4'd7;
  localparam logic [3:0] ALUC_LUI  = 4'd8;
  localparam logic [3:0] ALUC_LUI2 = 4'd9;
  localparam logic [3:0] ALUC_SLTU = 4'd10;
  localparam logic [3:0] ALUC_SLT  = 4'd11;
  localparam logic [3:0] ALUC_SRA  = 4'd12;
  localparam logic [3:0] ALUC_SRL  = 4'd13;
  localparam logic [3:0] ALUC_SLL  = 4'd14;
  localparam logic [3:0] ALUC_SLL2 = 4'd15;

  localparam logic A_SEL_RS    = 1'b0;
  localparam logic A_SEL_SHAMT = 1'b1;
  localparam logic B_SEL_RT    = 1'b0;
  localparam logic B_SEL_IMM   = 1'b1;

endpackage

// File: rtl/fwd_mux.sv
// rtl/fwd_mux.sv - per-source operand forwarding select
module fwd_mux (
  input  logic [4:0]  src,
  input  logic [31:0] rf_val,
  input  logic        exm_reg_write,
  input  logic        exm_is_load,
  input  logic [4:0]  exm_rd,
  input  logic [31:0] exm_result,
  input  logic        mw_reg_write,
  input  logic [4:0]  mw_rd,
  input  logic [31:0] mw_result,
  output logic [31:0] fwd_val
);

  logic w_src_nz;
  logic w_hit_exm;
  logic w_hit_mw;

  // A load in EX/MEM has no data yet; the hazard unit stalls instead.
  assign w_src_nz  = (src != 5'd0);
  assign w_hit_exm = exm_reg_write && !exm_is_load && (exm_rd == src) && w_src_nz;
  assign w_hit_mw  = mw_reg_write && (mw_rd == src) && w_src_nz;

  always_comb begin
    fwd_val = rf_val;
    if (w_hit_exm)
      fwd_val = exm_result;
    else if (w_hit_mw)
      fwd_val = mw_result;
  end

endmodule

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - ID/EX operand capture with forwarding and load-use stall
module alu_operand_stage
  import cpu54_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [31:0] id_rs_val,
  input  logic [31:0] id_rt_val,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_shamt,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [3:0]  id_aluc,
  input  logic        id_a_sel,
  input  logic        id_b_sel,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        exm_reg_write,
  input  logic        exm_is_load,
  input  logic [4:0]  exm_rd,
  input  logic [31:0] exm_result,
  input  logic        mw_reg_write,
  input  logic [4:0]  mw_rd,
  input  logic [31:0] mw_result,
  input  logic        flush,
  input  logic        ex_ready,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_aluc,
  output logic        ex_valid,
  output logic [4:0]  ex_rd,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic [31:0] ex_store_data,
  output logic        load_use_stall
);

  logic [31:0] w_rs_fwd;
  logic [31:0] w_rt_fwd;
  logic [31:0] w_a_next;
  logic [31:0] w_b_next;
  logic        w_stall;
  logic        w_capture;

  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic [3:0]  r_aluc;
  logic        r_valid;
  logic [4:0]  r_rd;
  logic        r_reg_write;
  logic        r_mem_read;
  logic [31:0] r_store_data;

  fwd_mux u_fwd_rs (
    .src           (id_rs),
    .rf_val        (id_rs_val),
    .exm_reg_write (exm_reg_write),
    .exm_is_load   (exm_is_load),
    .exm_rd        (exm_rd),
    .exm_result    (exm_result),
    .mw_reg_write  (mw_reg_write),
    .mw_rd         (mw_rd),
    .mw_result     (mw_result),
    .fwd_val       (w_rs_fwd)
  );

  fwd_mux u_fwd_rt (
    .src           (id_rt),
    .rf_val        (id_rt_val),
    .exm_reg_write (exm_reg_write),
    .exm_is_load   (exm_is_load),
    .exm_rd        (exm_rd),
    .exm_result    (exm_result),
    .mw_reg_write  (mw_reg_write),
    .mw_rd         (mw_rd),
    .mw_result     (mw_result),
    .fwd_val       (w_rt_fwd)
  );

  assign w_stall = id_valid && exm_is_load && exm_reg_write && (exm_rd != 5'd0) &&
                   ((id_uses_rs && (exm_rd == id_rs)) || (id_uses_rt && (exm_rd == id_rt)));

  assign id_ready  = (!r_valid || ex_ready) && !w_stall;
  assign w_capture = id_valid && id_ready;

  assign w_a_next = (id_a_sel == A_SEL_SHAMT) ? {27'b0, id_shamt} : w_rs_fwd;
  assign w_b_next = (id_b_sel == B_SEL_IMM)   ? id_imm            : w_rt_fwd;

  // Data registers only move on capture; a drained or flushed slot keeps stale data
  // but always carries cleared control bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a      <= 32'd0;
      r_alu_b      <= 32'd0;
      r_aluc       <= 4'd0;
      r_valid      <= 1'b0;
      r_rd         <= 5'd0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_store_data <= 32'd0;
    end else if (flush) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
    end else if (w_capture) begin
      r_alu_a      <= w_a_next;
      r_alu_b      <= w_b_next;
      r_aluc       <= id_aluc;
      r_valid      <= 1'b1;
      r_rd         <= id_rd;
      r_reg_write  <= id_reg_write;
      r_mem_read   <= id_mem_read;
      r_store_data <= w_rt_fwd;
    end else if (ex_ready) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
    end
  end

  assign alu_a          = r_alu_a;
  assign alu_b          = r_alu_b;
  assign alu_aluc       = r_aluc;
  assign ex_valid       = r_valid;
  assign ex_rd          = r_rd;
  assign ex_reg_write   = r_reg_write;
  assign ex_mem_read    = r_mem_read;
  assign ex_store_data  = r_store_data;
  assign load_use_stall = w_stall;

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - directed bench for alu_operand_stage
module tb_alu_operand_stage;
  import cpu54_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_rs_val, id_rt_val, id_imm;
  logic [4:0]  id_shamt, id_rs, id_rt, id_rd;
  logic [3:0]  id_aluc;
  logic        id_a_sel, id_b_sel, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read;
  logic        exm_reg_write, exm_is_load;
  logic [4:0]  exm_rd;
  logic [31:0] exm_result;
  logic        mw_reg_write;
  logic [4:0]  mw_rd;
  logic [31:0] mw_result;
  logic        flush, ex_ready;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [3:0]  alu_aluc;
  logic        ex_valid, ex_reg_write, ex_mem_read, load_use_stall;
  logic [4:0]  ex_rd;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  alu_operand_stage dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm),
    .id_shamt(id_shamt), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_aluc(id_aluc), .id_a_sel(id_a_sel), .id_b_sel(id_b_sel),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .exm_reg_write(exm_reg_write), .exm_is_load(exm_is_load),
    .exm_rd(exm_rd), .exm_result(exm_result),
    .mw_reg_write(mw_reg_write), .mw_rd(mw_rd), .mw_result(mw_result),
    .flush(flush), .ex_ready(ex_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc),
    .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_store_data(ex_store_data), .load_use_stall(load_use_stall)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic defaults();
    id_valid = 0; id_rs_val = 0; id_rt_val = 0; id_imm = 0; id_shamt = 0;
    id_rs = 0; id_rt = 0; id_rd = 0; id_aluc = ALUC_ADDU;
    id_a_sel = A_SEL_RS; id_b_sel = B_SEL_RT; id_uses_rs = 1; id_uses_rt = 1;
    id_reg_write = 0; id_mem_read = 0;
    exm_reg_write = 0; exm_is_load = 0; exm_rd = 0; exm_result = 0;
    mw_reg_write = 0; mw_rd = 0; mw_result = 0;
    flush = 0; ex_ready = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    defaults();
    rst_n = 0;
    #3;
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_aluc", alu_aluc, 0);
    check("rst_ex_valid", ex_valid, 0);
    check("rst_ex_rd", ex_rd, 0);
    check("rst_reg_write", ex_reg_write, 0);
    check("rst_store", ex_store_data, 0);
    check("rst_id_ready", id_ready, 1);
    @(negedge clk);
    rst_n = 1;

    // EX/MEM wins over MEM/WB on rs
    id_valid = 1; id_rs = 3; id_rt = 4; id_rs_val = 32'hAAAA; id_rt_val = 32'h4444;
    id_aluc = ALUC_ADD; id_rd = 7; id_reg_write = 1;
    exm_reg_write = 1; exm_rd = 3; exm_result = 32'h10;
    mw_reg_write = 1; mw_rd = 3; mw_result = 32'h20;
    tick();
    check("prio_alu_a", alu_a, 32'h10);
    check("prio_alu_b", alu_b, 32'h4444);
    check("prio_aluc", alu_aluc, 2);
    check("prio_ex_valid", ex_valid, 1);
    check("prio_ex_rd", ex_rd, 7);
    check("prio_reg_write", ex_reg_write, 1);

    // MEM/WB forward on rt, immediate on b
    exm_rd = 9; mw_rd = 4; id_b_sel = B_SEL_IMM; id_imm = 32'h1234; id_mem_read = 1;
    tick();
    check("mw_alu_a", alu_a, 32'hAAAA);
    check("mw_alu_b_imm", alu_b, 32'h1234);
    check("mw_store", ex_store_data, 32'h20);
    check("mw_mem_read", ex_mem_read, 1);

    // r0 never forwarded
    defaults();
    id_valid = 1; id_rs = 0; id_rs_val = 32'h55;
    exm_reg_write = 1; exm_rd = 0; exm_result = 32'hFFFF;
    mw_reg_write = 1; mw_rd = 0; mw_result = 32'hEEEE;
    tick();
    check("r0_alu_a", alu_a, 32'h55);

    // load in EX/MEM, rt not used: no stall
    defaults();
    id_valid = 1; id_rs = 1; id_rt = 5; id_uses_rt = 0; id_reg_write = 1;
    exm_is_load = 1; exm_reg_write = 1; exm_rd = 5;
    #1;
    check("nouse_stall", load_use_stall, 0);
    check("nouse_ready", id_ready, 1);

    // load-use hazard on rt
    id_uses_rt = 1; id_rt_val = 32'h1;
    #1;
    check("lu_stall", load_use_stall, 1);
    check("lu_ready", id_ready, 0);
    tick();
    check("lu_bubble_valid", ex_valid, 0);
    check("lu_bubble_rw", ex_reg_write, 0);
    exm_is_load = 0; exm_reg_write = 0;
    mw_reg_write = 1; mw_rd = 5; mw_result = 32'h77;
    #1;
    check("lu_release_stall", load_use_stall, 0);
    check("lu_release_ready", id_ready, 1);
    tick();
    check("lu_cap_valid", ex_valid, 1);
    check("lu_cap_alu_b", alu_b, 32'h77);

    // downstream stall for 3 cycles
    defaults();
    id_valid = 1; id_rs_val = 32'hDEAD; id_rt_val = 32'hBEEF; id_aluc = ALUC_OR;
    ex_ready = 0;
    #1;
    check("hold_ready", id_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_alu_a", alu_a, 32'h0);
      check("hold_alu_b", alu_b, 32'h77);
      check("hold_aluc", alu_aluc, 0);
      check("hold_valid", ex_valid, 1);
    end
    ex_ready = 1;
    #1;
    check("resume_ready", id_ready, 1);
    tick();
    check("resume_alu_a", alu_a, 32'hDEAD);
    check("resume_aluc", alu_aluc, 5);

    // SLL with shamt
    defaults();
    id_valid = 1; id_a_sel = A_SEL_SHAMT; id_shamt = 5'd31; id_rs_val = 32'h99;
    id_rt_val = 32'h8; id_aluc = ALUC_SLL;
    tick();
    check("sll_alu_a", alu_a, 32'h1F);
    check("sll_alu_b", alu_b, 32'h8);
    check("sll_aluc", alu_aluc, 14);

    // flush beats capture
    id_reg_write = 1; flush = 1;
    tick();
    check("flush_valid", ex_valid, 0);
    check("flush_rw", ex_reg_write, 0);

    // capture then drain with no offer
    flush = 0;
    tick();
    check("drain_pre_valid", ex_valid, 1);
    id_valid = 0;
    tick();
    check("drain_valid", ex_valid, 0);
    check("drain_rw", ex_reg_write, 0);

    // async reset mid-hold
    id_valid = 1; id_rs_val = 32'h1234; id_a_sel = A_SEL_RS; id_rd = 3; id_mem_read = 1;
    tick();
    ex_ready = 0;
    tick();
    check("prerst_valid", ex_valid, 1);
    #2;
    rst_n = 0;
    #1;
    check("arst_alu_a", alu_a, 0);
    check("arst_alu_b", alu_b, 0);
    check("arst_valid", ex_valid, 0);
    check("arst_rd", ex_rd, 0);
    check("arst_mem_read", ex_mem_read, 0);
    check("arst_store", ex_store_data, 0);
    @(negedge clk);
    rst_n = 1;
    #1;
    check("post_rst_ready", id_ready, 1);
    tick();
    check("post_rst_valid", ex_valid, 1);
    check("post_rst_alu_a", alu_a, 32'h1234);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 The block SHALL have these ports (name direction width meaning):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  decode offers an instruction.
- id_ready  out  1  stage accepts the offer this cycle.
- id_rs_val, id_rt_val  in  32  register-file read data.
- id_imm  in  32  extended immediate.
- id_shamt  in  5  shift amount.
- id_rs, id_rt, id_rd  in  5  source and destination register numbers.
- id_aluc  in  4  ALU opcode.
- id_a_sel  in  1  0 = rs, 1 = zero-extended shamt.
- id_b_sel  in  1  0 = rt, 1 = imm.
- id_uses_rs, id_uses_rt  in  1  the operand is actually read.
- id_reg_write, id_mem_read  in  1  control bits carried forward.
- exm_reg_write, exm_is_load  in  1  EX/MEM producer info.
- exm_rd  in  5  EX/MEM destination.
- exm_result  in  32  EX/MEM result.
- mw_reg_write  in  1  MEM/WB write enable.
- mw_rd  in  5  MEM/WB destination.
- mw_result  in  32  MEM/WB result.
- flush  in  1  kill the held instruction and the current offer.
- ex_ready  in  1  ALU stage consumes this cycle.
- alu_a, alu_b  out  32  ALU operands.
- alu_aluc  out  4  ALU opcode.
- ex_valid  out  1  registered outputs are valid.
- ex_rd  out  5  destination register.
- ex_reg_write, ex_mem_read  out  1  control bits.
- ex_store_data  out  32  forwarded rt value.
- load_use_stall  out  1  a hazard bubble is being inserted.

REQ-002 Parameter: none; widths are fixed at 32/5/4.

Function
REQ-003 Forwarding is resolved at capture time, per source s in {rs, rt}:
- If exm_reg_write, exm_rd == s, s != 0 and exm_is_load == 0, use exm_result.
- Else if mw_reg_write, mw_rd == s and s != 0, use mw_result.
- Else use the register-file value.
REQ-004 EX/MEM SHALL take priority over MEM/WB when both match.
REQ-005 Register 0 SHALL never be forwarded; its value is the register-file value.
REQ-006 alu_a SHALL be {27'b0, id_shamt} when id_a_sel = 1, otherwise forwarded rs.
REQ-007 alu_b SHALL be id_imm when id_b_sel = 1, otherwise forwarded rt.
REQ-008 ex_store_data SHALL always be forwarded rt.
REQ-009 load_use_stall SHALL be combinational and asserted when all of the following hold:
- id_valid is high.
- exm_is_load and exm_reg_write are high.
- exm_rd != 0.
- exm_rd matches an id_rs or id_rt whose uses bit is set.
REQ-010 id_ready SHALL equal (!ex_valid | ex_ready) & !load_use_stall.
REQ-011 Capture occurs on the clock edge when id_valid & id_ready; all outputs update and ex_valid goes to 1. Latency is one cycle.
REQ-012 When ex_valid & ex_ready and no capture occurs, ex_valid SHALL go to 0 (bubble).
REQ-013 When ex_valid & !ex_ready, all outputs SHALL hold unchanged (stall), and id_ready SHALL be 0.
REQ-014 During load_use_stall, a bubble SHALL be inserted if downstream drains: ex_valid = 0 and ex_reg_write = ex_mem_read = 0. The stall lasts exactly one cycle after the load advances.
REQ-015 flush has priority over capture and hold: next-cycle ex_valid = 0, ex_reg_write = 0 and ex_mem_read = 0; data outputs are don't-care.
REQ-016 While ex_valid = 0, ex_reg_write and ex_mem_read SHALL be 0.

Reset
REQ-017 rst_n low SHALL asynchronously clear all outputs:
- alu_a, alu_b and ex_store_data = 0.
- alu_aluc = 4'd0.
- ex_rd = 0.
- ex_valid, ex_reg_write and ex_mem_read = 0.
REQ-018 Reset mid-stall SHALL discard the held instruction; the first cycle after release SHALL show id_ready = 1 (absent a hazard).

Structure
REQ-019 ALU opcode constants (ADDU=0, SUBU=1, ADD=2, SUB=3, AND=4, OR=5, XOR=6, NOR=7, LUI=8/9, SLTU=10, SLT=11, SRA=12, SRL=13, SLL=14/15) and the a_sel/b_sel encodings SHALL live in shared package cpu54_pkg.
REQ-020 The forwarding selection SHALL be one sub-module, fwd_mux, instantiated twice (rs and rt).

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- ADD with rs=3, rt=4, exm_rd=3, exm_result=0x10, mw_rd=3, mw_result=0x20 -> alu_a = 0x10 one cycle later.
- rs=0, exm_rd=0, exm_reg_write=1, exm_result=0xFFFF -> alu_a = id_rs_val, with no forwarding.
- exm_is_load=1, exm_rd=5, id_rt=5, id_uses_rt=1 -> load_use_stall=1 and id_ready=0 for one cycle; next cycle ex_valid=0 with ex_reg_write=0.
- ex_ready=0 for 3 cycles with ex_valid=1 -> alu_a, alu_b and alu_aluc stable, id_ready=0; capture resumes on the cycle ex_ready=1.
- SLL with id_a_sel=1, shamt=31, id_b_sel=0 -> alu_a = 0x0000001F and alu_aluc = 4'd14.
- flush with id_valid=1 -> next cycle ex_valid=0; rst_n pulsed low asynchronously mid-hold -> all outputs 0 immediately.
